// File: rtl/thiele_cpu_kami_pkg.sv
// Shared definitions for the Thiele-machine CPU core.
// Contents: storage sizes, opcode values, error codes, instruction field
// slicing helpers and the legal-opcode predicate used by the decoder.
package thiele_cpu_kami_pkg;

    localparam int IMEM_DEPTH = 256;
    localparam int DMEM_DEPTH = 256;
    localparam int NREGS      = 32;
    localparam int NTENSOR    = 16;

    localparam logic [7:0] OP_PNEW       = 8'h00;
    localparam logic [7:0] OP_PSPLIT     = 8'h01;
    localparam logic [7:0] OP_PMERGE     = 8'h02;
    localparam logic [7:0] OP_MDLACC     = 8'h05;
    localparam logic [7:0] OP_PDISCOVER  = 8'h06;
    localparam logic [7:0] OP_XFER       = 8'h07;
    localparam logic [7:0] OP_CHSH_TRIAL = 8'h09;
    localparam logic [7:0] OP_XOR_LOAD   = 8'h0A;
    localparam logic [7:0] OP_XOR_ADD    = 8'h0B;
    localparam logic [7:0] OP_XOR_SWAP   = 8'h0C;
    localparam logic [7:0] OP_XOR_RANK   = 8'h0D;
    localparam logic [7:0] OP_REVEAL     = 8'h0F;
    localparam logic [7:0] OP_LOADI      = 8'h11;
    localparam logic [7:0] OP_STORE      = 8'h12;
    localparam logic [7:0] OP_HALT       = 8'hFF;

    localparam logic [31:0] ERR_NONE        = 32'd0;
    localparam logic [31:0] ERR_ILLEGAL_OP  = 32'd1;
    localparam logic [31:0] ERR_CHSH_FIELD  = 32'd2;
    localparam logic [31:0] ERR_MU_OVERFLOW = 32'd3;

    function automatic logic [7:0] f_opcode(input logic [31:0] instr);
        return instr[31:24];
    endfunction

    function automatic logic [7:0] f_a(input logic [31:0] instr);
        return instr[23:16];
    endfunction

    function automatic logic [7:0] f_b(input logic [31:0] instr);
        return instr[15:8];
    endfunction

    function automatic logic [7:0] f_cost(input logic [31:0] instr);
        return instr[7:0];
    endfunction

    function automatic logic op_is_legal(input logic [7:0] op);
        case (op)
            OP_PNEW, OP_PSPLIT, OP_PMERGE, OP_MDLACC, OP_PDISCOVER, OP_XFER,
            OP_CHSH_TRIAL, OP_XOR_LOAD, OP_XOR_ADD, OP_XOR_SWAP, OP_XOR_RANK,
            OP_REVEAL, OP_LOADI, OP_STORE, OP_HALT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/thiele_cpu_kami_popcount.sv
// Population count of a 32-bit word, used by XOR_RANK.
// Ports: word (in, 32) - value to count; count (out, 6) - number of set bits.
module thiele_popcount32 (
    input  logic [31:0] word,
    output logic [5:0]  count
);

    always_comb begin
        count = 6'd0;
        for (int i = 0; i < 32; i++) begin
            count = count + {5'd0, word[i]};
        end
    end

endmodule

// File: rtl/thiele_cpu_kami.sv
// Single-issue Thiele-machine CPU core: one instruction per cycle from an
// internal 256-word instruction memory, with a 32-entry register file,
// 256-word data memory, mu-cost accounting and a 16-entry mu-tensor.
// Ports:
//   CLK, RST_N            clock (rising edge), asynchronous active-low reset
//   loadInstr_x_0[39:0]   {addr[7:0], instr[31:0]} written to imem[addr]
//   EN_loadInstr          load strobe; RDY_loadInstr is always 1
//   getX / EN_getX / RDY_getX   always-ready architectural state getters
//                               (EN_getX is accepted and ignored)
// Handshake: a method fires on any edge where EN_x is high; RDY_x is a
// constant 1, so a caller never has to wait and no request is ever held off.
module thiele_cpu_kami
    import thiele_cpu_kami_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [39:0] loadInstr_x_0,
    input  logic        EN_loadInstr,
    output logic        RDY_loadInstr,
    input  logic        EN_getPC,
    output logic [31:0] getPC,
    output logic        RDY_getPC,
    input  logic        EN_getMu,
    output logic [31:0] getMu,
    output logic        RDY_getMu,
    input  logic        EN_getPartitionOps,
    output logic [31:0] getPartitionOps,
    output logic        RDY_getPartitionOps,
    input  logic        EN_getMdlOps,
    output logic [31:0] getMdlOps,
    output logic        RDY_getMdlOps,
    input  logic        EN_getInfoGain,
    output logic [31:0] getInfoGain,
    output logic        RDY_getInfoGain,
    input  logic        EN_getErrorCode,
    output logic [31:0] getErrorCode,
    output logic        RDY_getErrorCode,
    input  logic        EN_getErr,
    output logic        getErr,
    output logic        RDY_getErr,
    input  logic        EN_getHalted,
    output logic        getHalted,
    output logic        RDY_getHalted,
    input  logic        EN_getMuTensor0,
    output logic [31:0] getMuTensor0,
    output logic        RDY_getMuTensor0,
    input  logic        EN_getMuTensor1,
    output logic [31:0] getMuTensor1,
    output logic        RDY_getMuTensor1,
    input  logic        EN_getMuTensor2,
    output logic [31:0] getMuTensor2,
    output logic        RDY_getMuTensor2,
    input  logic        EN_getMuTensor3,
    output logic [31:0] getMuTensor3,
    output logic        RDY_getMuTensor3,
    input  logic        EN_getBianchiAlarm,
    output logic        getBianchiAlarm,
    output logic        RDY_getBianchiAlarm
);

    // Architectural state (names are relied on for hierarchical peeks).
    logic [31:0]               pc, mu, partition_ops, mdl_ops, info_gain, error_code;
    logic                      err, halted;
    logic [NREGS*32-1:0]       regs;
    logic [DMEM_DEPTH*32-1:0]  mem;
    logic [IMEM_DEPTH*32-1:0]  imem;
    logic [NTENSOR*32-1:0]     mu_tensor;

    logic [31:0] instr;
    logic [7:0]  op, fa, fb, fc;
    logic [9:0]  ra_off, rb_off;
    logic [8:0]  t_off;
    logic [31:0] val_a, val_b, mem_val, tensor_val, exec_code;
    logic [32:0] mu_sum;
    logic [5:0]  rank;
    logic [35:0] tensor_sum;
    logic        step, load_we, bianchi_alarm;

    assign instr   = imem[{pc[7:0], 5'd0} +: 32];
    assign op      = f_opcode(instr);
    assign fa      = f_a(instr);
    assign fb      = f_b(instr);
    assign fc      = f_cost(instr);
    assign ra_off  = {fa[4:0], 5'd0};
    assign rb_off  = {fb[4:0], 5'd0};
    assign t_off   = {fa[3:0], 5'd0};
    assign val_a   = regs[ra_off +: 32];
    assign val_b   = regs[rb_off +: 32];
    assign mem_val = mem[{fb, 5'd0} +: 32];
    assign tensor_val = mu_tensor[t_off +: 32];
    assign mu_sum  = {1'b0, mu} + {25'd0, fc};
    assign step    = !halted && !err;

    thiele_popcount32 u_popcount (
        .word  (val_b),
        .count (rank)
    );

    // Decode faults outrank the mu overflow; an instruction that faults
    // commits nothing but the error flag and code.
    always_comb begin
        exec_code = ERR_NONE;
        if (!op_is_legal(op)) begin
            exec_code = ERR_ILLEGAL_OP;
        end else if (op == OP_CHSH_TRIAL && (fa[7:2] != 6'd0 || fb[7:2] != 6'd0)) begin
            exec_code = ERR_CHSH_FIELD;
        end else if (mu_sum[32]) begin
            exec_code = ERR_MU_OVERFLOW;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc            <= '0;
            mu            <= '0;
            partition_ops <= '0;
            mdl_ops       <= '0;
            info_gain     <= '0;
            error_code    <= '0;
            err           <= 1'b0;
            halted        <= 1'b0;
            regs          <= '0;
            mem           <= '0;
            mu_tensor     <= '0;
        end else if (step) begin
            if (exec_code != ERR_NONE) begin
                err        <= 1'b1;
                error_code <= exec_code;
            end else begin
                mu <= mu_sum[31:0];
                // HALT parks pc on itself so getPC shows the halting address.
                if (op == OP_HALT) begin
                    halted <= 1'b1;
                end else begin
                    pc <= pc + 32'd1;
                end
                case (op)
                    OP_PNEW, OP_PSPLIT, OP_PMERGE: partition_ops <= partition_ops + 32'd1;
                    OP_MDLACC:    mdl_ops   <= mdl_ops + 32'd1;
                    OP_PDISCOVER: info_gain <= info_gain + {24'd0, fb};
                    OP_XFER:      regs[ra_off +: 32] <= val_b;
                    OP_XOR_LOAD:  regs[ra_off +: 32] <= mem_val;
                    OP_XOR_ADD:   regs[ra_off +: 32] <= val_a ^ val_b;
                    OP_XOR_SWAP: begin
                        regs[ra_off +: 32] <= val_b;
                        regs[rb_off +: 32] <= val_a;
                    end
                    OP_XOR_RANK:  regs[ra_off +: 32] <= {26'd0, rank};
                    OP_REVEAL:    mu_tensor[t_off +: 32] <= tensor_val + {24'd0, fc};
                    OP_LOADI:     regs[ra_off +: 32] <= {24'd0, fb};
                    OP_STORE:     mem[{fb, 5'd0} +: 32] <= val_a;
                    default: ;
                endcase
            end
        end
    end

    // imem keeps its contents across reset; a load coinciding with an
    // asserted reset is dropped.
    assign load_we = EN_loadInstr & RST_N;

    always_ff @(posedge CLK) begin
        if (load_we) begin
            imem[{loadInstr_x_0[39:32], 5'd0} +: 32] <= loadInstr_x_0[31:0];
        end
    end

    // Consistency alarm: charged mu must cover everything revealed.
    always_comb begin
        tensor_sum = 36'd0;
        for (int i = 0; i < NTENSOR; i++) begin
            tensor_sum = tensor_sum + {4'd0, mu_tensor[9'(i * 32) +: 32]};
        end
    end
    assign bianchi_alarm = {4'd0, mu} < tensor_sum;

    assign getPC           = pc;
    assign getMu           = mu;
    assign getPartitionOps = partition_ops;
    assign getMdlOps       = mdl_ops;
    assign getInfoGain     = info_gain;
    assign getErrorCode    = error_code;
    assign getErr          = err;
    assign getHalted       = halted;
    assign getMuTensor0    = mu_tensor[0 +: 32];
    assign getMuTensor1    = mu_tensor[32 +: 32];
    assign getMuTensor2    = mu_tensor[64 +: 32];
    assign getMuTensor3    = mu_tensor[96 +: 32];
    assign getBianchiAlarm = bianchi_alarm;

    assign RDY_loadInstr       = 1'b1;
    assign RDY_getPC           = 1'b1;
    assign RDY_getMu           = 1'b1;
    assign RDY_getPartitionOps = 1'b1;
    assign RDY_getMdlOps       = 1'b1;
    assign RDY_getInfoGain     = 1'b1;
    assign RDY_getErrorCode    = 1'b1;
    assign RDY_getErr          = 1'b1;
    assign RDY_getHalted       = 1'b1;
    assign RDY_getMuTensor0    = 1'b1;
    assign RDY_getMuTensor1    = 1'b1;
    assign RDY_getMuTensor2    = 1'b1;
    assign RDY_getMuTensor3    = 1'b1;
    assign RDY_getBianchiAlarm = 1'b1;

    // Getter enables carry no meaning for always-ready getters.
    logic unused_en;
    assign unused_en = ^{EN_getPC, EN_getMu, EN_getPartitionOps, EN_getMdlOps,
                         EN_getInfoGain, EN_getErrorCode, EN_getErr, EN_getHalted,
                         EN_getMuTensor0, EN_getMuTensor1, EN_getMuTensor2,
                         EN_getMuTensor3, EN_getBianchiAlarm};

endmodule

// File: tb/tb_thiele_cpu_kami.sv
// Self-checking bench for thiele_cpu_kami: directed scenarios followed by
// random programs compared against an instruction-level reference model.
module tb_thiele_cpu_kami;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [39:0] loadInstr_x_0 = '0;
    logic        EN_loadInstr = 1'b0;
    logic        RDY_loadInstr;
    logic        en_get = 1'b0;
    logic [13:0] rdy_get;
    logic [31:0] getPC, getMu, getPartitionOps, getMdlOps, getInfoGain, getErrorCode;
    logic [31:0] getMuTensor0, getMuTensor1, getMuTensor2, getMuTensor3;
    logic        getErr, getHalted, getBianchiAlarm;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [31:0] m_pc, m_mu, m_part, m_mdl, m_info, m_ec;
    logic        m_err, m_halted;
    logic [31:0] m_regs [32];
    logic [31:0] m_mem [256];
    logic [31:0] m_tensor [16];
    logic [31:0] m_imem [256];

    logic [7:0] legal_ops [14] = '{8'h00, 8'h01, 8'h02, 8'h05, 8'h06, 8'h07, 8'h09,
                                   8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0F, 8'h11, 8'h12};

    thiele_cpu_kami dut (
        .CLK(CLK), .RST_N(RST_N),
        .loadInstr_x_0(loadInstr_x_0), .EN_loadInstr(EN_loadInstr), .RDY_loadInstr(RDY_loadInstr),
        .EN_getPC(en_get), .getPC(getPC), .RDY_getPC(rdy_get[0]),
        .EN_getMu(en_get), .getMu(getMu), .RDY_getMu(rdy_get[1]),
        .EN_getPartitionOps(en_get), .getPartitionOps(getPartitionOps), .RDY_getPartitionOps(rdy_get[2]),
        .EN_getMdlOps(en_get), .getMdlOps(getMdlOps), .RDY_getMdlOps(rdy_get[3]),
        .EN_getInfoGain(en_get), .getInfoGain(getInfoGain), .RDY_getInfoGain(rdy_get[4]),
        .EN_getErrorCode(en_get), .getErrorCode(getErrorCode), .RDY_getErrorCode(rdy_get[5]),
        .EN_getErr(en_get), .getErr(getErr), .RDY_getErr(rdy_get[6]),
        .EN_getHalted(en_get), .getHalted(getHalted), .RDY_getHalted(rdy_get[7]),
        .EN_getMuTensor0(en_get), .getMuTensor0(getMuTensor0), .RDY_getMuTensor0(rdy_get[8]),
        .EN_getMuTensor1(en_get), .getMuTensor1(getMuTensor1), .RDY_getMuTensor1(rdy_get[9]),
        .EN_getMuTensor2(en_get), .getMuTensor2(getMuTensor2), .RDY_getMuTensor2(rdy_get[10]),
        .EN_getMuTensor3(en_get), .getMuTensor3(getMuTensor3), .RDY_getMuTensor3(rdy_get[11]),
        .EN_getBianchiAlarm(en_get), .getBianchiAlarm(getBianchiAlarm), .RDY_getBianchiAlarm(rdy_get[12])
    );

    assign rdy_get[13] = RDY_loadInstr;

    // Clock / reset
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_mu = 0; m_part = 0; m_mdl = 0; m_info = 0; m_ec = 0;
        m_err = 0; m_halted = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        for (int i = 0; i < 256; i++) m_mem[i] = 0;
        for (int i = 0; i < 16; i++) m_tensor[i] = 0;
    endtask

    // One architectural instruction, straight from the opcode table.
    task automatic model_step();
        logic [31:0] ins, t;
        logic [7:0]  op;
        int a, b, c, code;
        if (m_halted || m_err) return;
        ins = m_imem[m_pc % 256];
        op = ins[31:24]; a = int'(ins[23:16]); b = int'(ins[15:8]); c = int'(ins[7:0]);
        code = 0;
        if (!(op inside {8'h00, 8'h01, 8'h02, 8'h05, 8'h06, 8'h07, 8'h09, 8'h0A, 8'h0B,
                         8'h0C, 8'h0D, 8'h0F, 8'h11, 8'h12, 8'hFF})) code = 1;
        else if (op == 8'h09 && (a > 3 || b > 3)) code = 2;
        else if (longint'(m_mu) + longint'(c) > 64'hFFFF_FFFF) code = 3;
        if (code != 0) begin
            m_err = 1; m_ec = 32'(code);
            return;
        end
        m_mu = m_mu + 32'(c);
        case (op)
            8'h00, 8'h01, 8'h02: m_part = m_part + 1;
            8'h05: m_mdl = m_mdl + 1;
            8'h06: m_info = m_info + 32'(b);
            8'h07: m_regs[a % 32] = m_regs[b % 32];
            8'h0A: m_regs[a % 32] = m_mem[b];
            8'h0B: m_regs[a % 32] = m_regs[a % 32] ^ m_regs[b % 32];
            8'h0C: begin
                t = m_regs[a % 32]; m_regs[a % 32] = m_regs[b % 32]; m_regs[b % 32] = t;
            end
            8'h0D: m_regs[a % 32] = 32'($countones(m_regs[b % 32]));
            8'h0F: m_tensor[a % 16] = m_tensor[a % 16] + 32'(c);
            8'h11: m_regs[a % 32] = 32'(b);
            8'h12: m_mem[b] = m_regs[a % 32];
            default: ;
        endcase
        if (op == 8'hFF) m_halted = 1;
        else m_pc = m_pc + 1;
    endtask

    // Driver tasks (entered and left on a falling edge)
    task automatic load_word(input logic [7:0] addr, input logic [31:0] data);
        EN_loadInstr = 1'b1;
        loadInstr_x_0 = {addr, data};
        @(posedge CLK);
        if (RST_N) m_imem[addr] = data;
        @(negedge CLK);
        EN_loadInstr = 1'b0;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge CLK);
            model_step();
            @(negedge CLK);
        end
    endtask

    task automatic compare_model();
        longint tsum;
        tsum = 0;
        for (int i = 0; i < 16; i++) tsum += longint'(m_tensor[i]);
        check("rnd_pc", getPC, m_pc);
        check("rnd_mu", getMu, m_mu);
        check("rnd_err", getErr, m_err);
        check("rnd_error_code", getErrorCode, m_ec);
        check("rnd_halted", getHalted, m_halted);
        check("rnd_partition_ops", getPartitionOps, m_part);
        check("rnd_mdl_ops", getMdlOps, m_mdl);
        check("rnd_info_gain", getInfoGain, m_info);
        check("rnd_tensor0", getMuTensor0, m_tensor[0]);
        check("rnd_tensor3", getMuTensor3, m_tensor[3]);
        check("rnd_alarm", getBianchiAlarm, (longint'(m_mu) < tsum) ? 1 : 0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [7:0] op, a, b, c;
        int r;
        r = $urandom_range(0, 99);
        if (r < 1) op = 8'h33;
        else if (r < 2) op = 8'hFF;
        else op = legal_ops[$urandom_range(0, 13)];
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        c = 8'($urandom_range(0, 15));
        if (op == 8'h09) begin
            a = 8'($urandom_range(0, 4));
            b = 8'($urandom_range(0, 4));
        end
        return {op, a, b, c};
    endfunction

    initial begin
        #1 RST_N = 1'b0;
        model_reset();
        #1;
        check("reset_pc", getPC, 0);
        check("reset_mu", getMu, 0);
        check("reset_err", getErr, 0);
        check("reset_halted", getHalted, 0);
        check("reset_error_code", getErrorCode, 0);
        check("reset_alarm", getBianchiAlarm, 0);
        check("rdy_all", rdy_get, 14'h3FFF);

        // Clear imem so the empty-memory program is all PNEW/cost 0.
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 256; i++) load_word(8'(i), 32'h0);
        do_reset();
        run(10);
        check("empty_partition_ops", getPartitionOps, 10);
        check("empty_pc", getPC, 10);
        check("empty_mu", getMu, 0);

        // LOADI / STORE / HALT
        load_word(8'd0, 32'h11_01_05_02);
        load_word(8'd1, 32'h12_01_07_01);
        load_word(8'd2, 32'hFF_00_00_00);
        do_reset();
        run(4);
        check("prog_reg1", dut.regs[63:32], 5);
        check("prog_mem7", dut.mem[7*32 +: 32], 5);
        check("prog_mu", getMu, 3);
        check("prog_halted", getHalted, 1);
        check("prog_pc", getPC, 2);

        // CHSH field checks
        load_word(8'd0, 32'h09_03_02_00);
        load_word(8'd1, 32'h09_04_00_00);
        do_reset();
        run(1);
        check("chsh_ok_err", getErr, 0);
        check("chsh_ok_pc", getPC, 1);
        run(3);
        check("chsh_bad_err", getErr, 1);
        check("chsh_bad_code", getErrorCode, 2);
        check("chsh_bad_pc", getPC, 1);

        // Illegal opcode
        load_word(8'd0, 32'h33_00_00_07);
        do_reset();
        run(3);
        check("illegal_err", getErr, 1);
        check("illegal_code", getErrorCode, 1);
        check("illegal_pc", getPC, 0);
        check("illegal_mu", getMu, 0);

        // Load into the word being fetched: the old word executes.
        load_word(8'd0, 32'h11_01_05_00);
        load_word(8'd1, 32'h11_02_06_00);
        do_reset();
        EN_loadInstr = 1'b1;
        loadInstr_x_0 = {8'd0, 32'h33_00_00_00};
        @(posedge CLK);
        model_step();
        m_imem[0] = 32'h33_00_00_00;
        @(negedge CLK);
        EN_loadInstr = 1'b0;
        check("collide_reg1", dut.regs[63:32], 5);
        check("collide_err", getErr, 0);
        check("collide_pc", getPC, 1);
        check("collide_imem0", dut.imem[31:0], 32'h33_00_00_00);

        // REVEAL and the consistency alarm
        load_word(8'd0, 32'h0F_02_00_05);
        load_word(8'd1, 32'hFF_00_00_00);
        do_reset();
        force dut.mu = 32'd0;
        #1 release dut.mu;
        run(2);
        check("reveal_mu", getMu, 5);
        check("reveal_tensor2", getMuTensor2, 5);
        check("reveal_alarm", getBianchiAlarm, 0);
        force dut.mu = 32'd0;
        #1;
        check("alarm_set", getBianchiAlarm, 1);
        release dut.mu;

        // mu overflow, then asynchronous reset mid-cycle with a pending load
        load_word(8'd0, 32'h00_00_00_01);
        do_reset();
        force dut.mu = 32'hFFFF_FFFF;
        @(posedge CLK);
        @(negedge CLK);
        check("ovf_err", getErr, 1);
        check("ovf_code", getErrorCode, 3);
        check("ovf_mu", getMu, 32'hFFFF_FFFF);
        check("ovf_pc", getPC, 0);
        check("ovf_partition_ops", getPartitionOps, 0);
        release dut.mu;
        EN_loadInstr = 1'b1;
        loadInstr_x_0 = {8'd5, 32'hDEAD_BEEF};
        #2 RST_N = 1'b0;
        model_reset();
        #1;
        check("async_pc", getPC, 0);
        check("async_mu", getMu, 0);
        check("async_err", getErr, 0);
        check("async_code", getErrorCode, 0);
        check("async_halted", getHalted, 0);
        @(posedge CLK);
        @(negedge CLK);
        EN_loadInstr = 1'b0;
        check("async_load_dropped", dut.imem[5*32 +: 32], m_imem[5]);
        check("async_imem_kept", dut.imem[31:0], 32'h00_00_00_01);
        RST_N = 1'b1;

        // Random programs against the reference model
        for (int round = 0; round < 5; round++) begin
            for (int i = 0; i < 64; i++) load_word(8'(i), rand_instr());
            do_reset();
            for (int cyc = 0; cyc < 60; cyc++) begin
                run(1);
                compare_model();
            end
            for (int i = 0; i < 32; i++) check("rnd_reg", dut.regs[i*32 +: 32], m_regs[i]);
            for (int i = 0; i < 256; i++) check("rnd_mem", dut.mem[i*32 +: 32], m_mem[i]);
            for (int i = 0; i < 16; i++) check("rnd_tensor", dut.mu_tensor[i*32 +: 32], m_tensor[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
